// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: scroll register addresses, direction and FSM encodings.
// Imported by the scroll writer, its interface and its testbench.
package ppu_pkg;

    localparam logic [15:0] SCY_ADDR = 16'hFF42;
    localparam logic [15:0] SCX_ADDR = 16'hFF43;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_RIGHT, DIR_LEFT} dir_t;

    typedef enum logic {IDLE, HOLD} scroll_state_t;

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scroll_mmio_writer_if.sv
// Button-in / MMIO-write-out bundle of scroll_mmio_writer, plus FSM debug visibility.
// slave = the writer itself, master = whoever drives the buttons and watches the bus.
interface scroll_mmio_writer_if;
    import ppu_pkg::*;

    logic          btn_up;
    logic          btn_down;
    logic          btn_left;
    logic          btn_right;

    // mmio_wr is a one-cycle strobe with no backpressure: the ppu takes
    // mmio_a/mmio_din on every cycle mmio_wr is high; both hold otherwise.
    logic [15:0]   mmio_a;
    logic [7:0]    mmio_din;
    logic          mmio_wr;
    logic [7:0]    scroll_x;
    logic [7:0]    scroll_y;

    scroll_state_t dbg_state;
    logic [7:0]    dbg_repeat_cnt;
    logic          dbg_accel;

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right,
        output mmio_a, mmio_din, mmio_wr, scroll_x, scroll_y,
        output dbg_state, dbg_repeat_cnt, dbg_accel
    );

    modport master (
        output btn_up, btn_down, btn_left, btn_right,
        input  mmio_a, mmio_din, mmio_wr, scroll_x, scroll_y,
        input  dbg_state, dbg_repeat_cnt, dbg_accel
    );

endinterface

// File: rtl/autorepeat_timer.sv
// Loadable down-counter for auto-repeat timing; o_zero flags the cycle a repeat is due.
// Load wins over decrement; the count never wraps below zero.
module autorepeat_timer #(
    parameter int unsigned CW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/scroll_mmio_writer.sv
// Turns held direction buttons into SCY/SCX MMIO writes with keyboard-style auto-repeat.
// Optional macro SCROLL_ACCEL_EN: shortens the repeat period after ACCEL_AFTER repeats.
module scroll_mmio_writer
    import ppu_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 1048576,
    parameter int unsigned REPEAT_PERIOD = 524288,
    parameter int unsigned ACCEL_AFTER   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    scroll_mmio_writer_if.slave  io_bus
);

    localparam int unsigned CNT_MAX = umax(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] DELAY_LD  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LD = CW'(REPEAT_PERIOD - 1);
    localparam logic [7:0]    ACCEL_TH  = 8'((ACCEL_AFTER > 255) ? 255 : ACCEL_AFTER);
`ifdef SCROLL_ACCEL_EN
    localparam logic [CW-1:0] FAST_LD   = CW'(umax(REPEAT_PERIOD >> 2, 1) - 1);
`endif

    scroll_state_t r_state;
    dir_t          r_dir;
    logic [7:0]    r_x;
    logic [7:0]    r_y;
    logic [15:0]   r_a;
    logic [7:0]    r_din;
    logic          r_wr;
    logic [7:0]    r_repeat_cnt;

    dir_t          w_sel_dir;
    dir_t          w_wr_dir;
    logic          w_any;
    logic          w_held;
    logic          w_zero;
    logic          w_press;
    logic          w_repeat_fire;
    logic          w_load;
    logic          w_dec;
    logic [CW-1:0] w_period_ld;
    logic [CW-1:0] w_load_val;
    logic          w_is_y;
    logic [15:0]   w_wr_addr;
    logic [7:0]    w_wr_data;

    assign w_any = io_bus.btn_up | io_bus.btn_down | io_bus.btn_right | io_bus.btn_left;

    // Fixed priority up > down > right > left.
    always_comb begin
        w_sel_dir = DIR_LEFT;
        if (io_bus.btn_up)         w_sel_dir = DIR_UP;
        else if (io_bus.btn_down)  w_sel_dir = DIR_DOWN;
        else if (io_bus.btn_right) w_sel_dir = DIR_RIGHT;
    end

    always_comb begin
        w_held = 1'b0;
        case (r_dir)
            DIR_UP:    w_held = io_bus.btn_up;
            DIR_DOWN:  w_held = io_bus.btn_down;
            DIR_RIGHT: w_held = io_bus.btn_right;
            DIR_LEFT:  w_held = io_bus.btn_left;
            default:   w_held = 1'b0;
        endcase
    end

    assign w_press       = (r_state == IDLE) && w_any;
    assign w_repeat_fire = (r_state == HOLD) && w_held && w_zero;
    assign w_dec         = (r_state == HOLD) && w_held && !w_zero;
    assign w_load        = w_press || w_repeat_fire;

    // Acceleration looks at the repeat count before this repeat is counted.
`ifdef SCROLL_ACCEL_EN
    assign w_period_ld = (r_repeat_cnt >= ACCEL_TH) ? FAST_LD : PERIOD_LD;
`else
    assign w_period_ld = PERIOD_LD;
`endif
    assign w_load_val = w_press ? DELAY_LD : w_period_ld;

    // A fresh press writes in the newly selected direction, a repeat in the latched one.
    assign w_wr_dir = (r_state == IDLE) ? w_sel_dir : r_dir;

    always_comb begin
        w_is_y    = (w_wr_dir == DIR_UP) || (w_wr_dir == DIR_DOWN);
        w_wr_addr = w_is_y ? SCY_ADDR : SCX_ADDR;
        w_wr_data = r_x;
        case (w_wr_dir)
            DIR_UP:    w_wr_data = r_y - 8'd1;
            DIR_DOWN:  w_wr_data = r_y + 8'd1;
            DIR_RIGHT: w_wr_data = r_x + 8'd1;
            DIR_LEFT:  w_wr_data = r_x - 8'd1;
            default:   w_wr_data = r_x;
        endcase
    end

    autorepeat_timer #(.CW(CW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_dir        <= DIR_UP;
            r_x          <= 8'd0;
            r_y          <= 8'd0;
            r_a          <= 16'h0000;
            r_din        <= 8'd0;
            r_wr         <= 1'b0;
            r_repeat_cnt <= 8'd0;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_dir        <= w_sel_dir;
                        r_repeat_cnt <= 8'd0;
                        r_state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (!w_held) begin
                        r_state <= IDLE;
`ifdef SCROLL_ACCEL_EN
                        r_repeat_cnt <= 8'd0;
`endif
                    end else if (w_zero && (r_repeat_cnt != 8'hFF)) begin
                        r_repeat_cnt <= r_repeat_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_press || w_repeat_fire) begin
                r_wr  <= 1'b1;
                r_a   <= w_wr_addr;
                r_din <= w_wr_data;
                if (w_is_y) r_y <= w_wr_data;
                else        r_x <= w_wr_data;
            end
        end
    end

    assign io_bus.mmio_a         = r_a;
    assign io_bus.mmio_din       = r_din;
    assign io_bus.mmio_wr        = r_wr;
    assign io_bus.scroll_x       = r_x;
    assign io_bus.scroll_y       = r_y;
    assign io_bus.dbg_state      = r_state;
    assign io_bus.dbg_repeat_cnt = r_repeat_cnt;
    assign io_bus.dbg_accel      = (r_repeat_cnt >= ACCEL_TH);

endmodule

// File: tb/tb_scroll_mmio_writer.sv
// Bench for scroll_mmio_writer: vector table, hand-written corner sequences, and random
// button traffic checked against a time-based reference model of the auto-repeat rules.
module tb_scroll_mmio_writer;
    import ppu_pkg::*;

    localparam int unsigned D = 4;
    localparam int unsigned P = 2;
    localparam int unsigned A = 2;
`ifdef SCROLL_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    localparam logic [3:0] B_UP    = 4'b1000;
    localparam logic [3:0] B_DOWN  = 4'b0100;
    localparam logic [3:0] B_RIGHT = 4'b0010;
    localparam logic [3:0] B_LEFT  = 4'b0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    scroll_mmio_writer_if bus ();

    scroll_mmio_writer #(
        .REPEAT_DELAY  (D),
        .REPEAT_PERIOD (P),
        .ACCEL_AFTER   (A)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic set_btn(input logic [3:0] b);
        bus.btn_up    = b[3];
        bus.btn_down  = b[2];
        bus.btn_right = b[1];
        bus.btn_left  = b[0];
    endtask

    task automatic tick(input logic r, input logic [3:0] b);
        rst = r;
        set_btn(b);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic check_out(input string tag, input logic wr, input logic [15:0] a,
                             input logic [7:0] din, input logic [7:0] x, input logic [7:0] y);
        check({tag, ".wr"},  32'(bus.mmio_wr),  32'(wr));
        check({tag, ".a"},   32'(bus.mmio_a),   32'(a));
        check({tag, ".din"}, 32'(bus.mmio_din), 32'(din));
        check({tag, ".x"},   32'(bus.scroll_x), 32'(x));
        check({tag, ".y"},   32'(bus.scroll_y), 32'(y));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic [3:0]  btn;
        logic        wr;
        logic [15:0] a;
        logic [7:0]  din;
        logic [7:0]  x;
        logic [7:0]  y;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] b, input logic wr, input logic [15:0] a,
                       input logic [7:0] din, input logic [7:0] x, input logic [7:0] y);
        vec_t v;
        v.rst = r; v.btn = b; v.wr = wr; v.a = a; v.din = din; v.x = x; v.y = y;
        vecs.push_back(v);
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [23:0] exp_q[$];
    int          m_t;
    bit          m_active;
    int          m_dir;
    int          m_next;
    int          m_reps;
    logic        m_wr;
    logic [15:0] m_a;
    logic [7:0]  m_din;
    logic [7:0]  m_x;
    logic [7:0]  m_y;

    task automatic m_write();
        case (m_dir)
            0: begin m_y = m_y - 8'd1; m_a = 16'hFF42; m_din = m_y; end
            1: begin m_y = m_y + 8'd1; m_a = 16'hFF42; m_din = m_y; end
            2: begin m_x = m_x + 8'd1; m_a = 16'hFF43; m_din = m_x; end
            default: begin m_x = m_x - 8'd1; m_a = 16'hFF43; m_din = m_x; end
        endcase
        m_wr = 1'b1;
        exp_q.push_back({m_a, m_din});
    endtask

    // One clock edge of the press/repeat rules, timed with absolute cycle numbers.
    task automatic model_step(input logic r, input logic [3:0] b);
        int gap;
        m_wr = 1'b0;
        if (r) begin
            m_active = 0; m_a = '0; m_din = '0; m_x = '0; m_y = '0; m_reps = 0;
        end else if (!m_active) begin
            if (b != 4'b0) begin
                m_dir = b[3] ? 0 : b[2] ? 1 : b[1] ? 2 : 3;
                m_write();
                m_active = 1;
                m_next = m_t + int'(D);
                m_reps = 0;
            end
        end else if (!b[3 - m_dir]) begin
            m_active = 0;
        end else if (m_t == m_next) begin
            m_write();
            gap = int'(P);
            if (ACCEL && m_reps >= int'(A)) gap = ((P >> 2) > 0) ? int'(P >> 2) : 1;
            m_next = m_t + gap;
            m_reps++;
        end
        m_t++;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [3:0] cur;
        logic       r;

        set_btn(4'b0);

        // Reset state.
        tick(1'b1, 4'b0);
        tick(1'b1, 4'b0);
        check_out("reset", 1'b0, 16'h0000, 8'd0, 8'd0, 8'd0);
        check("reset.state", 32'(bus.dbg_state), 32'(IDLE));
        check("reset.repcnt", 32'(bus.dbg_repeat_cnt), 32'd0);
        check("reset.accel", 32'(bus.dbg_accel), 32'd0);

        // Single short press of down: one write only.
        add(1'b1, 4'b0,    1'b0, 16'h0000, 8'd0, 8'd0, 8'd0);
        add(1'b0, B_DOWN,  1'b1, 16'hFF42, 8'd1, 8'd0, 8'd1);
        add(1'b0, 4'b0,    1'b0, 16'hFF42, 8'd1, 8'd0, 8'd1);
        add(1'b0, 4'b0,    1'b0, 16'hFF42, 8'd1, 8'd0, 8'd1);
        add(1'b0, 4'b0,    1'b0, 16'hFF42, 8'd1, 8'd0, 8'd1);
        add(1'b0, 4'b0,    1'b0, 16'hFF42, 8'd1, 8'd0, 8'd1);
        // Up held 12 cycles from reset: delay 4, then period 2, wrapping below zero.
        add(1'b1, 4'b0,    1'b0, 16'h0000, 8'd0,   8'd0, 8'd0);
        add(1'b0, B_UP,    1'b1, 16'hFF42, 8'd255, 8'd0, 8'd255);
        add(1'b0, B_UP,    1'b0, 16'hFF42, 8'd255, 8'd0, 8'd255);
        add(1'b0, B_UP,    1'b0, 16'hFF42, 8'd255, 8'd0, 8'd255);
        add(1'b0, B_UP,    1'b0, 16'hFF42, 8'd255, 8'd0, 8'd255);
        add(1'b0, B_UP,    1'b1, 16'hFF42, 8'd254, 8'd0, 8'd254);
        add(1'b0, B_UP,    1'b0, 16'hFF42, 8'd254, 8'd0, 8'd254);
        add(1'b0, B_UP,    1'b1, 16'hFF42, 8'd253, 8'd0, 8'd253);
        add(1'b0, B_UP,    1'b0, 16'hFF42, 8'd253, 8'd0, 8'd253);
        add(1'b0, B_UP,    1'b1, 16'hFF42, 8'd252, 8'd0, 8'd252);
        if (ACCEL) begin
            add(1'b0, B_UP, 1'b1, 16'hFF42, 8'd251, 8'd0, 8'd251);
            add(1'b0, B_UP, 1'b1, 16'hFF42, 8'd250, 8'd0, 8'd250);
            add(1'b0, B_UP, 1'b1, 16'hFF42, 8'd249, 8'd0, 8'd249);
            add(1'b0, 4'b0, 1'b0, 16'hFF42, 8'd249, 8'd0, 8'd249);
        end else begin
            add(1'b0, B_UP, 1'b0, 16'hFF42, 8'd252, 8'd0, 8'd252);
            add(1'b0, B_UP, 1'b1, 16'hFF42, 8'd251, 8'd0, 8'd251);
            add(1'b0, B_UP, 1'b0, 16'hFF42, 8'd251, 8'd0, 8'd251);
            add(1'b0, 4'b0, 1'b0, 16'hFF42, 8'd251, 8'd0, 8'd251);
        end

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].btn);
            check_out($sformatf("vec%0d", i), vecs[i].wr, vecs[i].a, vecs[i].din,
                      vecs[i].x, vecs[i].y);
        end

        // Up+left together: only SCY writes; dropping up yields one idle cycle then SCX.
        tick(1'b1, 4'b0);
        tick(1'b0, B_UP | B_LEFT);
        check_out("combo.first", 1'b1, 16'hFF42, 8'd255, 8'd0, 8'd255);
        tick(1'b0, B_UP | B_LEFT);
        check_out("combo.hold1", 1'b0, 16'hFF42, 8'd255, 8'd0, 8'd255);
        tick(1'b0, B_UP | B_LEFT);
        check_out("combo.hold2", 1'b0, 16'hFF42, 8'd255, 8'd0, 8'd255);
        tick(1'b0, B_LEFT);
        check_out("combo.release", 1'b0, 16'hFF42, 8'd255, 8'd0, 8'd255);
        check("combo.state", 32'(bus.dbg_state), 32'(IDLE));
        tick(1'b0, B_LEFT);
        check_out("combo.left", 1'b1, 16'hFF43, 8'd255, 8'd255, 8'd255);

        // Right held, reset pulsed between repeats, then a fresh press.
        tick(1'b1, 4'b0);
        tick(1'b0, B_RIGHT);
        check_out("rst.first", 1'b1, 16'hFF43, 8'd1, 8'd1, 8'd0);
        tick(1'b0, B_RIGHT);
        tick(1'b0, B_RIGHT);
        check_out("rst.gap", 1'b0, 16'hFF43, 8'd1, 8'd1, 8'd0);
        tick(1'b0, B_RIGHT);
        tick(1'b0, B_RIGHT);
        check_out("rst.repeat", 1'b1, 16'hFF43, 8'd2, 8'd2, 8'd0);
        tick(1'b1, B_RIGHT);
        check_out("rst.edge", 1'b0, 16'h0000, 8'd0, 8'd0, 8'd0);
        check("rst.state", 32'(bus.dbg_state), 32'(IDLE));
        tick(1'b0, B_RIGHT);
        check_out("rst.fresh", 1'b1, 16'hFF43, 8'd1, 8'd1, 8'd0);

        // Random traffic against the reference model.
        m_t = 0; m_active = 0; m_dir = 0; m_next = 0; m_reps = 0;
        tick(1'b1, 4'b0);
        model_step(1'b1, 4'b0);
        cur = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) cur = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 149) == 0);
            tick(r, cur);
            model_step(r, cur);
            check_out($sformatf("rand%0d", c), m_wr, m_a, m_din, m_x, m_y);
            if (bus.mmio_wr && exp_q.size() != 0)
                check($sformatf("rand%0d.wrdata", c), {8'd0, bus.mmio_a, bus.mmio_din},
                      {8'd0, exp_q.pop_front()});
        end
        check("exp_q.drained", 32'(exp_q.size()), 32'd0);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
